// File: rtl/addmulor_pkg.sv
// rtl/addmulor_pkg.sv - shared types and helpers for the add-mul-or scheduler
package addmulor_pkg;

  // Widest requester index the pipeline tag can carry (up to 256 requesters)
  localparam int TAG_ID_W = 8;

  // Requester ID width: at least one bit even for a single requester
  function automatic int id_w_f(input int n_req);
    return (n_req > 2) ? $clog2(n_req) : 1;
  endfunction

  // Tag travelling alongside each datapath slot
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Golden reference: ((d + a) * b) | c at full precision, truncated to width bits
  function automatic logic [31:0] addmulor_f(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] c,
                                             input logic [31:0] d,
                                             input int          width);
    logic [63:0] sum;
    logic [63:0] prod;
    logic [63:0] res;
    logic [63:0] mask;
    sum  = {32'd0, d} + {32'd0, a};
    prod = sum * {32'd0, b};
    res  = prod | {32'd0, c};
    mask = (64'd1 << width) - 64'd1;
    return 32'(res & mask);
  endfunction

endpackage

// File: rtl/addmulor_pipe.sv
// rtl/addmulor_pipe.sv - fixed-latency add-mul-or datapath with tag shift register
module addmulor_pipe
  import addmulor_pkg::*;
#(
  parameter int WIDTH      = 9,
  parameter int PIPE_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  tag_t             tag_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  output tag_t             tag_o,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o
);

  logic [PIPE_DEPTH-1:0] valid_q;
  logic [TAG_ID_W-1:0]   id_q [PIPE_DEPTH];
  logic [WIDTH-1:0]      a_q;
  logic [WIDTH-1:0]      b_q;
  logic [WIDTH-1:0]      c_q;
  logic [WIDTH-1:0]      d_q;
  logic [WIDTH-1:0]      res_s1;

  // Slot valids shift every cycle; these are the only reset state in the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= tag_i.valid;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Requester IDs follow their slot; meaningless while the matching valid is low
  always_ff @(posedge clk) begin
    id_q[0] <= tag_i.id;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      id_q[i] <= id_q[i-1];
    end
  end

  // Stage 1 captures operands only for real issues to avoid needless toggling
  always_ff @(posedge clk) begin
    if (tag_i.valid) begin
      a_q <= a_i;
      b_q <= b_i;
      c_q <= c_i;
      d_q <= d_i;
    end
  end

  // Modulo-2^WIDTH arithmetic: truncating every intermediate is exact
  assign res_s1 = ((d_q + a_q) * b_q) | c_q;

  if (PIPE_DEPTH == 1) begin : g_direct
    assign data_o = res_s1;
  end else begin : g_res_chain
    logic [WIDTH-1:0] res_q [PIPE_DEPTH-1];

    // Result delay line for stages 2..PIPE_DEPTH
    always_ff @(posedge clk) begin
      res_q[0] <= res_s1;
      for (int i = 1; i < PIPE_DEPTH - 1; i++) begin
        res_q[i] <= res_q[i-1];
      end
    end

    assign data_o = res_q[PIPE_DEPTH-2];
  end

  assign tag_o  = '{valid: valid_q[PIPE_DEPTH-1], id: id_q[PIPE_DEPTH-1]};
  assign busy_o = |valid_q;

endmodule

// File: rtl/addmulor_rr_scheduler.sv
// rtl/addmulor_rr_scheduler.sv - round-robin scheduler sharing one add-mul-or pipeline
module addmulor_rr_scheduler
  import addmulor_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int WIDTH      = 9,
  parameter  int PIPE_DEPTH = 3,
  parameter  int RSP_DEPTH  = 4,
  localparam int ID_W       = id_w_f(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*WIDTH-1:0] req_c,
  input  logic [N_REQ*WIDTH-1:0] req_d,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [ID_W-1:0]  rr_q;
  logic [ID_W-1:0]  rr_d;
  logic [CNT_W-1:0] credits_q;
  logic [CNT_W-1:0] credits_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] wr_d;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] rd_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;
  logic             issue;
  logic             push;
  logic             pop;

  tag_t             issue_tag;
  logic [WIDTH-1:0] issue_a;
  logic [WIDTH-1:0] issue_b;
  logic [WIDTH-1:0] issue_c;
  logic [WIDTH-1:0] issue_d;

  tag_t             pipe_tag;
  logic [WIDTH-1:0] pipe_data;
  logic             pipe_busy;

  logic [WIDTH-1:0] data_mem [RSP_DEPTH];
  logic [ID_W-1:0]  id_mem   [RSP_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == RSP_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin search: first valid requester at or after the pointer
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(rr_q) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Issue needs a credit; reset gates the grant so req_ready drops with rst_n
  assign issue = rst_n & grant_found & (credits_q != '0);
  assign pop   = rsp_valid & rsp_ready;
  assign push  = pipe_tag.valid;

  // One-hot grant plus the operand and tag mux feeding stage 1
  always_comb begin
    req_ready = '0;
    if (issue) begin
      req_ready[grant_idx] = 1'b1;
    end
    issue_tag.valid = issue;
    issue_tag.id    = TAG_ID_W'(grant_idx);
    issue_a         = req_a[int'(grant_idx)*WIDTH +: WIDTH];
    issue_b         = req_b[int'(grant_idx)*WIDTH +: WIDTH];
    issue_c         = req_c[int'(grant_idx)*WIDTH +: WIDTH];
    issue_d         = req_d[int'(grant_idx)*WIDTH +: WIDTH];
  end

  addmulor_pipe #(
    .WIDTH      (WIDTH),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_i  (issue_tag),
    .a_i    (issue_a),
    .b_i    (issue_b),
    .c_i    (issue_c),
    .d_i    (issue_d),
    .tag_o  (pipe_tag),
    .data_o (pipe_data),
    .busy_o (pipe_busy)
  );

  // Next-state for RR pointer, credits and FIFO bookkeeping
  always_comb begin
    rr_d = rr_q;
    if (issue) begin
      rr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + ID_W'(1);
    end

    credits_d = credits_q;
    if (issue && !pop) begin
      credits_d = credits_q - CNT_W'(1);
    end else if (!issue && pop) begin
      credits_d = credits_q + CNT_W'(1);
    end

    wr_d = push ? ptr_inc(wr_q) : wr_q;
    rd_d = pop  ? ptr_inc(rd_q) : rd_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control state; in-flight ops vanish because pipe valids and FIFO count clear together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= '0;
      credits_q <= CNT_W'(RSP_DEPTH);
      count_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
    end else begin
      rr_q      <= rr_d;
      credits_q <= credits_d;
      count_q   <= count_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

  // Response storage; credits guarantee a free entry whenever the pipe delivers
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_q] <= pipe_data;
      id_mem[wr_q]   <= ID_W'(pipe_tag.id);
    end
  end

  assign rsp_valid = (count_q != '0);
  assign rsp_id    = id_mem[rd_q];
  assign rsp_data  = data_mem[rd_q];
  assign busy      = pipe_busy | (count_q != '0);

endmodule

// File: tb/tb_addmulor_rr_scheduler.sv
// tb/tb_addmulor_rr_scheduler.sv - scoreboard bench for addmulor_rr_scheduler
module tb_addmulor_rr_scheduler;
  import addmulor_pkg::*;

  localparam int N = 4;
  localparam int W = 9;

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*W-1:0] req_c;
  logic [N*W-1:0] req_d;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           busy;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           exp_next = 0;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic [W-1:0] op_c [N];
  logic [W-1:0] op_d [N];

  addmulor_rr_scheduler #(
    .N_REQ      (N),
    .WIDTH      (W),
    .PIPE_DEPTH (3),
    .RSP_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_d     (req_d),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every popped response must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected_queue_size", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(e.id));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end
  end

  // Single requester issues; waits for the grant and records the hand-computed result
  task automatic send(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] res);
    bit           got = 1'b0;
    logic [N-1:0] oh;
    oh = 4'b0001 << idx;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_c[idx*W +: W] = c;
    req_d[idx*W +: W] = d;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        check("grant_single", 64'(req_ready), 64'(oh));
        sb_q.push_back('{id: idx, data: res});
        exp_next = (idx + 1) % N;
      end
    end
    if (!got) check("send_grant_timeout", 64'(req_ready), 64'(oh));
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  // All requesters valid for a number of cycles; grants must follow the rotation
  task automatic run_all(input int cycles, output int grants, output int first);
    logic [N-1:0] oh;
    grants = 0;
    first  = -1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
      req_c[i*W +: W] = op_c[i];
      req_d[i*W +: W] = op_d[i];
    end
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        oh = 4'b0001 << exp_next;
        check("rr_order", 64'(req_ready), 64'(oh));
        sb_q.push_back('{id: exp_next,
                         data: W'(addmulor_f(32'(op_a[exp_next]), 32'(op_b[exp_next]),
                                             32'(op_c[exp_next]), 32'(op_d[exp_next]), W))});
        if (first < 0) first = k;
        grants++;
        exp_next = (exp_next + 1) % N;
      end
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) done = 1'b1;
    end
    if (!done) check("idle_timeout_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int f;

    op_a = '{9'd10, 9'h1F0, 9'd7,  9'd255};
    op_b = '{9'd3,  9'h1FF, 9'd0,  9'd17};
    op_c = '{9'd0,  9'h040, 9'h1A, 9'd1};
    op_d = '{9'd5,  9'h020, 9'd9,  9'd200};

    // Reset with all requesters valid: nothing may be granted
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    #12;
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;

    // Single op from requester 2 and its latency
    send(2, 9'd3, 9'd5, 9'h100, 9'd4, 9'h123);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("latency_rsp_valid", 64'(rsp_valid), (k == 3) ? 64'd1 : 64'd0);
      if (k == 3) begin
        check("single_rsp_id", 64'(rsp_id), 64'd2);
        check("single_rsp_data", 64'(rsp_data), 64'h123);
      end
    end
    wait_idle();

    // Modulo wrap cases
    send(1, 9'h1FF, 9'd2, 9'h000, 9'h1FF, 9'h1FC);
    send(3, 9'h100, 9'h100, 9'h001, 9'h100, 9'h001);
    wait_idle();

    // Continuous contention with a free consumer: credit round trip gives 4 grants per 5 cycles
    run_all(20, g, f);
    check("all_valid_grants", 64'(g), 64'd16);
    check("all_valid_first", 64'(f), 64'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();

    // Stalled consumer: credits cap accepts at 4, one pop releases exactly one more
    rsp_ready = 1'b0;
    run_all(12, g, f);
    check("stall_grants", 64'(g), 64'd4);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_no_credit_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    run_all(6, g, f);
    check("after_pop_grants", 64'(g), 64'd1);
    check("after_pop_first", 64'(f), 64'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();

    // Last credit: issue and pop on the same edge keep one credit
    rsp_ready = 1'b0;
    run_all(3, g, f);
    check("credit1_setup_grants", 64'(g), 64'd3);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    run_all(1, g, f);
    check("credit1_issue_with_pop", 64'(g), 64'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    run_all(4, g, f);
    check("credit1_next_grants", 64'(g), 64'd1);
    check("credit1_next_first", 64'(f), 64'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset while work is in flight and a response is waiting
    rsp_ready = 1'b0;
    send(0, 9'd1, 9'd1, 9'd0, 9'd1, 9'd2);
    send(1, 9'd2, 9'd3, 9'd0, 9'd2, 9'd12);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    check("async_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_req_ready", 64'(req_ready), 64'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("held_reset_req_ready", 64'(req_ready), 64'd0);
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    exp_next  = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    run_all(1, g, f);
    check("post_reset_grant", 64'(g), 64'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
